ls_dispatch_queue: RTL
======================

// Module: ls_dispatch_queue
// PURPOSE
//  In-order load/store buffer between the reservation station (RAS) and dcache_top.
//  Accepts LS ops from RAS and presents the oldest entry on the dcache request interface.
//  Loads issue as soon as they reach the head.
//  Stores are held at the head until the ROB reports them as the retiring instruction.
//  A ROB resteer flushes every entry.
// PARAMETERS
//  DEPTH         8   number of entries; power of 2, >= 2
//  OOO_TAG_SIZE  10  width of rename/ROB tag
// PORTS
//  clk            in   1             single clock; all state updates on rising edge
//  rst            in   1             reset, asynchronous, active-low
//  ras_valid      in   1             RAS presents an LS op this cycle
//  ras_addr       in   32            effective address
//  ras_data       in   32            store data (don't-care for loads)
//  ras_size       in   2             00 byte, 01 half, 10 word, 11 reserved
//  ras_is_st      in   1             1 = store, 0 = load
//  ras_ooo_tag    in   OOO_TAG_SIZE  rename tag of the op
//  ras_ready      out  1             queue can accept an op this cycle
//  ls_unit_alloc  out  1             head entry valid toward dcache
//  addr_in        out  32            head address
//  data_in        out  32            head data
//  size_in        out  2             head size
//  is_st_in       out  1             head is store
//  ooo_tag_in     out  OOO_TAG_SIZE  head tag
//  dc_ready       in   1             dcache accepts the head this cycle
//  rob_ret_tag_in in   OOO_TAG_SIZE  tag at top of ROB
//  rob_valid      in   1             rob_ret_tag_in is valid
//  rob_resteer    in   1             flush request from ROB
//  lsq_count      out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - Pointers and count go to 0.
//   - Head FSM goes to EMPTY.
//   - Outputs: ls_unit_alloc=0, ras_ready=1, lsq_count=0.
//   - Payload outputs are 0.
//  Storage:
//   - Circular array indexed by rd_ptr/wr_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH.
//   - count tracks occupancy.
//   - full = (count==DEPTH); empty = (count==0).
//  Push:
//   - ras_ready = !full, combinational.
//   - push = ras_valid & ras_ready & !rob_resteer.
//   - Entry is written at wr_ptr on the clock edge and is visible at the head no earlier
//     than the next cycle (1-cycle minimum latency RAS->dcache).
//   - ras_valid while full: the op is not captured. RAS must hold it.
//   - ras_size=11 is stored and forwarded unchanged.
//  Head FSM (evaluated on the entry at rd_ptr):
//   - EMPTY: count==0.
//     -> LD_ISSUE if the head entry is a load.
//     -> ST_WAIT if the head entry is a store.
//   - LD_ISSUE: ls_unit_alloc=1.
//   - ST_WAIT: ls_unit_alloc=0.
//     -> ST_ISSUE when rob_valid & (rob_ret_tag_in == head tag).
//   - ST_ISSUE: ls_unit_alloc=1. The commit is latched, so the store stays issuable even
//     if the ROB top moves on.
//   - Payload outputs always mirror the head entry.
//   - Payload outputs are 0 in EMPTY.
//  Pop:
//   - pop = ls_unit_alloc & dc_ready & !rob_resteer.
//   - rd_ptr advances and the FSM re-evaluates the next entry (next-state from the new head).
//   - While dc_ready=0, payload and ls_unit_alloc hold stable; no retraction.
//  Simultaneous push and pop:
//   - Count is unchanged.
//   - Legal at any non-full occupancy. When full, push is blocked by ras_ready.
//   - Push into empty with no pop: entry appears next cycle.
//  Resteer (rob_resteer=1):
//   - ls_unit_alloc is forced to 0 combinationally in that cycle.
//   - On the edge: all entries dropped, pointers and count -> 0, FSM -> EMPTY.
//   - Push and pop are both suppressed that cycle.
//   - A latched store commit is discarded.
//  Reset mid-operation: all queued ops are lost; no output pulse during or after reset.
// TESTING
//  - Reset: assert rst=0 mid-stream with 3 entries -> ls_unit_alloc=0, lsq_count=0,
//    ras_ready=1 immediately.
//  - Load path: push LD addr=0x100 tag=5, dc_ready=1 -> next cycle ls_unit_alloc=1,
//    addr_in=0x100; popped the same cycle; count 1->0.
//  - Store gating: push ST tag=7 data=0xDEADBEEF; rob_ret_tag_in=6 -> alloc stays 0.
//    Set tag=7, rob_valid=1 -> alloc=1 next cycle and holds after the ROB tag changes.
//  - Full/backpressure: dc_ready=0, push DEPTH loads -> ras_ready=0, lsq_count=8.
//    9th op not captured. dc_ready=1 -> order preserved on the way out.
//  - Wrap and concurrent push/pop: 20 ops streamed with dc_ready toggling -> FIFO order
//    intact across pointer wrap; count correct on every push+pop cycle.
//  - Resteer: 5 entries plus push in the same cycle as rob_resteer=1 -> alloc=0 that cycle,
//    count=0 next cycle, the pushed op is dropped.

Source files
------------

// File: rtl/ls_dispatch_queue.sv
// In-order LS buffer RAS->dcache: 1-cycle min latency; loads issue at head, stores wait for ROB retire tag.
// Backpressure: ras_ready drops when full; head payload/alloc hold stable while dc_ready=0; resteer flushes all.
module ls_dispatch_queue #(
  parameter int DEPTH        = 8,
  parameter int OOO_TAG_SIZE = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ras_valid,
  input  logic [31:0]                  ras_addr,
  input  logic [31:0]                  ras_data,
  input  logic [1:0]                   ras_size,
  input  logic                         ras_is_st,
  input  logic [OOO_TAG_SIZE-1:0]      ras_ooo_tag,
  output logic                         ras_ready,
  output logic                         ls_unit_alloc,
  output logic [31:0]                  addr_in,
  output logic [31:0]                  data_in,
  output logic [1:0]                   size_in,
  output logic                         is_st_in,
  output logic [OOO_TAG_SIZE-1:0]      ooo_tag_in,
  input  logic                         dc_ready,
  input  logic [OOO_TAG_SIZE-1:0]      rob_ret_tag_in,
  input  logic                         rob_valid,
  input  logic                         rob_resteer,
  output logic [$clog2(DEPTH+1)-1:0]   lsq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0]             addr;
    logic [31:0]             data;
    logic [1:0]              size;
    logic                    is_st;
    logic [OOO_TAG_SIZE-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    LD_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } head_state_e;

  entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  head_state_e         state_q, state_d;

  entry_t              new_entry;
  entry_t              head;
  entry_t              next_head;
  logic                full;
  logic                push;
  logic                pop;
  logic                alloc;

  assign new_entry = '{addr:  ras_addr,
                       data:  ras_data,
                       size:  ras_size,
                       is_st: ras_is_st,
                       tag:   ras_ooo_tag};

  assign head      = mem_q[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign ras_ready = !full;
  assign push      = ras_valid & !full & !rob_resteer;
  assign alloc     = ((state_q == LD_ISSUE) || (state_q == ST_ISSUE)) & !rob_resteer;
  assign pop       = alloc & dc_ready;

  assign ls_unit_alloc = alloc;
  assign lsq_count     = count_q;

  always_comb begin
    addr_in    = '0;
    data_in    = '0;
    size_in    = '0;
    is_st_in   = 1'b0;
    ooo_tag_in = '0;
    if (state_q != EMPTY) begin
      addr_in    = head.addr;
      data_in    = head.data;
      size_in    = head.size;
      is_st_in   = head.is_st;
      ooo_tag_in = head.tag;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rob_resteer) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The new head may be the entry being written this very edge (push into an
  // empty queue, or push+pop at occupancy 1), so bypass it from the RAS inputs.
  always_comb begin
    state_d   = state_q;
    next_head = mem_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      next_head = new_entry;
    end
    if (rob_resteer || (count_d == '0)) begin
      state_d = EMPTY;
    end else if (pop || (state_q == EMPTY)) begin
      state_d = next_head.is_st ? ST_WAIT : LD_ISSUE;
    end else if ((state_q == ST_WAIT) && rob_valid && (rob_ret_tag_in == head.tag)) begin
      state_d = ST_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the head is EMPTY.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CNT_W'(DEPTH));
  a_alloc_nonempty: assert property (@(posedge clk) disable iff (!rst)
    ls_unit_alloc |-> (count_q != '0));
  a_empty_state: assert property (@(posedge clk) disable iff (!rst)
    (count_q == '0) == (state_q == EMPTY));

endmodule
